// File: rtl/jtcontra_gfx_pkg.sv
// Shared definitions for the 007121 graphics ROM arbiter.
//
// Contents:
//   RomAw / RomDw : default ROM word-address and data widths
//   st_e          : arbiter FSM state encoding
//   own_e         : requester identity (A = tilemap fetcher, B = object fetcher)
package jtcontra_gfx_pkg;

  localparam int unsigned RomAw = 18;
  localparam int unsigned RomDw = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } st_e;

  typedef enum logic {
    OwnA = 1'b0,
    OwnB = 1'b1
  } own_e;

endpackage

// File: rtl/jtcontra_gfx_romarb_pick.sv
// Combinational two-way round-robin picker with an optional B-priority override.
//
// Ports:
//   a_cs_i  : requester A wants the ROM
//   b_cs_i  : requester B wants the ROM
//   last_i  : requester that completed the most recent word
//   hb_i    : force ties to B (blanking-priority window)
//   req_o   : at least one requester is asking
//   grant_o : chosen requester; meaningful only when req_o is high
module jtcontra_gfx_romarb_pick
  import jtcontra_gfx_pkg::*;
(
  input  logic a_cs_i,
  input  logic b_cs_i,
  input  own_e last_i,
  input  logic hb_i,
  output logic req_o,
  output own_e grant_o
);

  always_comb begin
    req_o   = a_cs_i | b_cs_i;
    grant_o = OwnA;
    if (a_cs_i && b_cs_i) begin
      if (hb_i) begin
        grant_o = OwnB;
      end else begin
        // Tie: serve whoever did not finish the previous word.
        grant_o = (last_i == OwnA) ? OwnB : OwnA;
      end
    end else if (b_cs_i) begin
      grant_o = OwnB;
    end
  end

endmodule

// File: rtl/jtcontra_gfx_romarb.sv
// Shares the single graphics ROM SDRAM port of a 007121 between the tilemap
// fetcher (A) and the object fetcher (B). Each side keeps its level cs/ok
// handshake; the arbiter re-arbitrates after every completed word.
//
// Optional feature (macro JTCONTRA_GFX_ROMARB_HBPRI_EN): while lhbl_i is low,
// ties go to B so objects can fill their line buffer during blank. Without the
// macro, lhbl_i is ignored and pure round-robin applies.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   lhbl_i              : horizontal blank, active low
//   a_cs_i/a_addr_i     : tilemap request and word address
//   a_ok_o/a_data_o     : tilemap data valid (level) and data
//   b_cs_i/b_addr_i     : object request and word address
//   b_ok_o/b_data_o     : object data valid (level) and data
//   rom_cs_o/rom_addr_o : SDRAM request and address
//   rom_ok_i/rom_data_i : SDRAM data valid and data
module jtcontra_gfx_romarb
  import jtcontra_gfx_pkg::*;
#(
  parameter int unsigned AW = RomAw,
  parameter int unsigned DW = RomDw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lhbl_i,
  input  logic          a_cs_i,
  input  logic [AW-1:0] a_addr_i,
  output logic          a_ok_o,
  output logic [DW-1:0] a_data_o,
  input  logic          b_cs_i,
  input  logic [AW-1:0] b_addr_i,
  output logic          b_ok_o,
  output logic [DW-1:0] b_data_o,
  output logic          rom_cs_o,
  output logic [AW-1:0] rom_addr_o,
  input  logic          rom_ok_i,
  input  logic [DW-1:0] rom_data_i
);

  st_e           st_q, st_d;
  own_e          owner_q, owner_d;
  own_e          last_q, last_d;
  logic          rom_cs_q, rom_cs_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [DW-1:0] a_data_q, a_data_d;
  logic [DW-1:0] b_data_q, b_data_d;

  logic          hb;
  logic          pick_req;
  own_e          pick_grant;
  logic          own_cs;
  logic [AW-1:0] own_addr;
  logic          own_match;

`ifdef JTCONTRA_GFX_ROMARB_HBPRI_EN
  assign hb = ~lhbl_i;
`else
  logic unused_lhbl;
  assign unused_lhbl = lhbl_i;
  assign hb          = 1'b0;
`endif

  jtcontra_gfx_romarb_pick u_pick (
    .a_cs_i  (a_cs_i),
    .b_cs_i  (b_cs_i),
    .last_i  (last_q),
    .hb_i    (hb),
    .req_o   (pick_req),
    .grant_o (pick_grant)
  );

  // The current owner still wants exactly the word that is on the ROM bus.
  always_comb begin
    own_cs    = (owner_q == OwnA) ? a_cs_i   : b_cs_i;
    own_addr  = (owner_q == OwnA) ? a_addr_i : b_addr_i;
    own_match = own_cs && (own_addr == rom_addr_q);
  end

  always_comb begin
    st_d       = st_q;
    owner_d    = owner_q;
    last_d     = last_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    a_data_d   = a_data_q;
    b_data_d   = b_data_q;

    unique case (st_q)
      StIdle: begin
        if (pick_req) begin
          owner_d    = pick_grant;
          rom_addr_d = (pick_grant == OwnA) ? a_addr_i : b_addr_i;
          rom_cs_d   = 1'b1;
          st_d       = StBusy;
        end
      end
      StBusy: begin
        // Abort wins over a simultaneous rom_ok: the data belongs to a word
        // nobody wants any more.
        if (!own_match) begin
          rom_cs_d = 1'b0;
          st_d     = StIdle;
        end else if (rom_ok_i) begin
          if (owner_q == OwnA) begin
            a_data_d = rom_data_i;
          end else begin
            b_data_d = rom_data_i;
          end
          rom_cs_d = 1'b0;
          last_d   = owner_q;
          st_d     = StDone;
        end
      end
      StDone: begin
        // Holding ok until the fetcher lets go also guarantees rom_cs stays
        // low at least one cycle before the next grant.
        if (!own_match) begin
          st_d = StIdle;
        end
      end
      default: begin
        rom_cs_d = 1'b0;
        st_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= StIdle;
      owner_q    <= OwnA;
      last_q     <= OwnB;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      a_data_q   <= '0;
      b_data_q   <= '0;
    end else begin
      st_q       <= st_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
    end
  end

  assign a_ok_o     = (st_q == StDone) && (owner_q == OwnA) && own_match;
  assign b_ok_o     = (st_q == StDone) && (owner_q == OwnB) && own_match;
  assign a_data_o   = a_data_q;
  assign b_data_o   = b_data_q;
  assign rom_cs_o   = rom_cs_q;
  assign rom_addr_o = rom_addr_q;

endmodule

// File: doc/jtcontra_gfx_romarb.md
Name: jtcontra_gfx_romarb

Overview:
Arbiter that shares the single 18-bit graphics ROM SDRAM port of one 007121 instance between two requesters: the tilemap fetcher (requester A) and the object/sprite fetcher (requester B).
It presents each requester with its own cs/addr/ok/data slot, all following the level handshake the fetchers already use. It sequences grants round-robin, re-arbitrating after every completed word.
It sits between the 007121 gfx engines and the SDRAM slot controller.

Parameters:
AW, 18, ROM address width (requester and SDRAM side).
DW, 16, ROM data width.

Ports:
clk  in  1  system clock; all logic posedge.
rst_n  in  1  asynchronous active-low reset.
LHBL  in  1  horizontal blank, active low; used only by the optional feature.
a_cs  in  1  tilemap request; held high until a_ok is seen.
a_addr  in  AW  tilemap word address.
a_ok  out  1  tilemap data valid (level).
a_data  out  DW  tilemap data.
b_cs  in  1  object request.
b_addr  in  AW  object word address.
b_ok  out  1  object data valid (level).
b_data  out  DW  object data.
rom_cs  out  1  SDRAM request.
rom_addr  out  AW  SDRAM address.
rom_ok  in  1  SDRAM data valid for current rom_addr.
rom_data  in  DW  SDRAM data.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rom_cs=0; rom_addr=0; a_ok=b_ok=0; a_data=b_data=0; owner=A; last=B, so A wins the first tie.
- State machine with registered outputs: IDLE, BUSY, DONE.
- IDLE:
  - Only one requester high: grant it.
  - Both high: grant the one that is not `last`.
  - On grant: latch owner and owner addr into rom_addr, rom_cs<=1, go to BUSY.
  - Latency: cs sampled at cycle N gives rom_cs=1 at N+1.
- BUSY, rom_ok=1: latch rom_data into the owner's data register; rom_cs<=0; last<=owner; go to DONE.
- BUSY, owner cs low or owner addr != rom_addr (abort): rom_cs<=0; go to IDLE; nothing captured; last unchanged. Abort is checked before rom_ok, so rom_ok in the abort cycle is ignored.
- DONE:
  - owner_ok = owner_cs & (owner_addr == rom_addr), evaluated combinationally on registered state.
  - When that condition goes false, go to IDLE on the next edge.
  - Net effect: a fetcher that keeps cs high and changes its address starts a new request, which competes in IDLE.
- Gap rule: rom_cs is always low for at least one cycle between two grants, so the SDRAM side sees a fresh edge per word.
- Non-owner ok is always 0. Data registers hold their last value until overwritten.
- rom_ok outside BUSY is ignored.
- Fairness: with both requesters continuously requesting, grants strictly alternate A,B,A,B.

Optional Feature:
- Macro: JTCONTRA_GFX_ROMARB_HBPRI_EN.
- Defined: while LHBL=0, a tie in IDLE always goes to B (objects fill their line buffer during blank). `last` is still updated. Outside blank, round-robin applies.
- Undefined: LHBL is ignored and pure round-robin applies at all times.

Decomposition:
- Shared package jtcontra_gfx_pkg:
  - State encoding (ST_IDLE, ST_BUSY, ST_DONE).
  - Owner encoding (OWN_A, OWN_B).
  - Default AW/DW constants.
- Natural sub-module: jtcontra_gfx_romarb_pick, a combinational priority picker with inputs a_cs, b_cs, last, hb and output grant. It is reused if a third requester is added later.

Test Plan:
1. Reset with rst_n low mid-BUSY (asynchronous) -> rom_cs, a_ok, b_ok and the data outputs go to 0 immediately, with no clock edge needed; state returns to IDLE.
2. a_cs=1, a_addr=18'h01234 at cycle 0; rom_ok=1, rom_data=16'hBEEF at cycle 4 -> rom_cs=1 in cycles 1-4; rom_addr=18'h01234; a_ok=1 and a_data=16'hBEEF from cycle 5 while a_cs stays high; b_ok=0 throughout.
3. a_cs and b_cs both held high, SDRAM answers every request after 2 cycles -> grant order A,B,A,B; rom_cs is low for at least 1 cycle between grants.
4. Abort: a_cs drops in BUSY before rom_ok; rom_ok then pulses one cycle later -> no a_ok; a_data unchanged; pending b request granted next.
5. Address change in DONE: a_addr goes 18'h00010 -> 18'h00011 with a_cs held high -> a_ok falls that cycle; a new grant presents rom_addr=18'h00011.
6. With JTCONTRA_GFX_ROMARB_HBPRI_EN defined, LHBL=0, both requesting, last=B -> B is granted. Without the macro -> A is granted.
